// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator and FIFO pixel transmitter; optional VIDEO_TIMING_GEN_TEST_PATTERN_EN
module video_timing_gen #(
    parameter int H_SYNC  = 40,
    parameter int H_BACK  = 220,
    parameter int H_DISP  = 1280,
    parameter int H_FRONT = 110,
    parameter int H_TOTAL = 1650,
    parameter int V_SYNC  = 5,
    parameter int V_BACK  = 20,
    parameter int V_DISP  = 720,
    parameter int V_FRONT = 5,
    parameter int V_TOTAL = 750
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
    input  logic       pattern_sel,
`endif
    output logic       src_req,
    input  logic [7:0] src_data,
    input  logic       src_empty,
    output logic       post_img_vsync,
    output logic       post_img_hsync,
    output logic       post_img_valid,
    output logic [7:0] post_img_data,
    output logic       frame_done,
    output logic       underflow
);

    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [VW-1:0] V_LAST     = VW'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BACK + V_DISP);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            run, vs, hs, act, frame_end;
    logic            pop_q;
    logic            pat_frame;
    logic [7:0]      pat_data_q;

    assign run       = (state == RUN);
    assign vs        = (v_cnt < V_SYNC_END);
    assign hs        = (h_cnt < H_SYNC_END);
    assign act       = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
                       (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    assign frame_end = run && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign src_req   = run && act && !pat_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A stop request is the live level of en: low at the frame's last position ends the run,
    // so raising en again anywhere earlier cancels it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (frame_end && !en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
    localparam int PW = (HW > VW) ? ((HW > 8) ? HW : 8) : ((VW > 8) ? VW : 8);

    logic [PW-1:0] col, row;
    assign col = PW'(h_cnt) - PW'(H_ACT_BEG);
    assign row = PW'(v_cnt) - PW'(V_ACT_BEG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_frame  <= 1'b0;
            pat_data_q <= 8'h00;
        end else begin
            if (run && (h_cnt == '0) && (v_cnt == '0)) pat_frame <= pattern_sel;
            pat_data_q <= (run && act && pat_frame) ? (col[7:0] ^ row[7:0]) : 8'h00;
        end
    end
`else
    assign pat_frame  = 1'b0;
    assign pat_data_q = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_img_vsync <= 1'b0;
            post_img_hsync <= 1'b0;
            post_img_valid <= 1'b0;
            frame_done     <= 1'b0;
            pop_q          <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            post_img_vsync <= run && vs;
            post_img_hsync <= run && hs;
            post_img_valid <= run && act;
            frame_done     <= frame_end;
            pop_q          <= src_req && !src_empty;
            underflow      <= underflow || (src_req && src_empty);
        end
    end

    // FIFO data arrives one cycle after the strobe, the same cycle the registered valid shows.
    assign post_img_data = pop_q ? src_data : pat_data_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized raster checks of video_timing_gen against a position-based model
module tb_video_timing_gen;

    localparam int HS = 1, HB = 2, HD = 15, HF = 2, HT = 20;
    localparam int VS = 1, VB = 2, VD = 15, VF = 2, VT = 20;
    localparam int FT = HT * VT;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, src_empty = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       src_req, post_img_vsync, post_img_hsync, post_img_valid, frame_done, underflow;
    logic [7:0] post_img_data;
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
    logic       pattern_sel = 1'b0;
`endif

    video_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .src_req(src_req), .src_data(src_data), .src_empty(src_empty),
        .post_img_vsync(post_img_vsync), .post_img_hsync(post_img_hsync),
        .post_img_valid(post_img_valid), .post_img_data(post_img_data),
        .frame_done(frame_done), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int    vectors = 0, miscompares = 0, cyc_bad = 0;
    string bad_note = "";

    // Model: a single raster position per frame plus the expected registered outputs.
    bit       m_run, m_pat;
    int       m_pos, fifo_next;
    bit       e_vs, e_hs, e_val, e_fd, e_uf;
    logic [7:0] e_data;
    int       empty_pix = -1;
    bit       rand_empty = 0;

    function automatic bit in_act(int pos);
        int h = pos % HT, v = pos / HT;
        return (h >= HS + HB) && (h < HS + HB + HD) && (v >= VS + VB) && (v < VS + VB + VD);
    endfunction

    function automatic int act_col(int pos); return pos % HT - HS - HB; endfunction
    function automatic int act_row(int pos); return pos / HT - VS - VB; endfunction

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_pat = 0;
        e_vs = 0; e_hs = 0; e_val = 0; e_fd = 0; e_uf = 0; e_data = 8'h00;
    endtask

    task automatic step();
        bit req, empty, pop, act;
        logic [13:0] obs, exp;
        act = m_run && in_act(m_pos);
        req = act && !m_pat;
        obs = {post_img_vsync, post_img_hsync, post_img_valid, frame_done, underflow, src_req, post_img_data};
        exp = {e_vs, e_hs, e_val, e_fd, e_uf, req, e_data};
        if (obs !== exp) begin
            cyc_bad++;
            if (cyc_bad == 1)
                bad_note = $sformatf("pos=%0d run=%0d got=%h want=%h", m_pos, m_run, obs, exp);
        end
        if (req) empty = rand_empty ? ($urandom_range(0, 15) == 0)
                                    : ((act_row(m_pos) * HD + act_col(m_pos)) == empty_pix);
        else     empty = $urandom_range(0, 1) == 1;
        pop = req && !empty;
        src_empty = empty;
        src_data  = pop ? fifo_next[7:0] : 8'($urandom);
        if (!rst_n) begin
            model_reset();
        end else begin
            e_vs   = m_run && (m_pos / HT < VS);
            e_hs   = m_run && (m_pos % HT < HS);
            e_val  = act;
            e_fd   = m_run && (m_pos == FT - 1);
            e_uf   = e_uf || (req && empty);
            e_data = pop ? fifo_next[7:0] : ((act && m_pat) ? 8'(act_col(m_pos) ^ act_row(m_pos)) : 8'h00);
            if (pop) fifo_next++;
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
            if (m_run && m_pos == 0) m_pat = pattern_sel;
`endif
            if (!m_run) begin
                if (en) m_run = 1;
            end else if (m_pos == FT - 1) begin
                m_pos = 0;
                if (!en) m_run = 0;
            end else begin
                m_pos++;
            end
        end
        @(negedge clk);
    endtask

    task automatic start_run();
        en = 0; rst_n = 0; model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1; fifo_next = 0; en = 1; cyc_bad = 0; bad_note = "";
        step();
    endtask

    task automatic test_reset();
        en = 1; rst_n = 0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        vectors++; if ({post_img_vsync, post_img_hsync, post_img_valid, frame_done} !== 4'b0) begin
            miscompares++; $display("FAIL reset_flags: got %b, expected 0000", {post_img_vsync, post_img_hsync, post_img_valid, frame_done}); end
        vectors++; if (post_img_data !== 8'h00) begin
            miscompares++; $display("FAIL reset_data: got %h, expected 00", post_img_data); end
        vectors++; if (underflow !== 1'b0) begin
            miscompares++; $display("FAIL reset_underflow: got %b, expected 0", underflow); end
        vectors++; if (src_req !== 1'b0) begin
            miscompares++; $display("FAIL reset_src_req: got %b, expected 0", src_req); end
    endtask

    task automatic test_geometry();
        int first_req = -1, first_val = -1, nval = 0, nlines = 0, vrun = 0, vrun_max = 0;
        int hs_len = 0, vs_len = 0, fd1 = -1, fd2 = -1;
        bit hs_done = 0, vs_done = 0, prev_val = 0;
        start_run();
        for (int k = 0; k < 820; k++) begin
            if (src_req && first_req < 0) first_req = k;
            if (post_img_valid && first_val < 0) first_val = k;
            if (k <= 400) begin
                if (post_img_valid) begin nval++; vrun++; if (vrun > vrun_max) vrun_max = vrun; end
                else vrun = 0;
                if (post_img_valid && !prev_val) nlines++;
                prev_val = post_img_valid;
            end
            if (post_img_hsync) begin if (!hs_done) hs_len++; end else if (hs_len > 0) hs_done = 1;
            if (post_img_vsync) begin if (!vs_done) vs_len++; end else if (vs_len > 0) vs_done = 1;
            if (frame_done) begin if (fd1 < 0) fd1 = k; else if (fd2 < 0) fd2 = k; end
            step();
        end
        vectors++; if (first_req != 63) begin miscompares++; $display("FAIL first_src_req: got %0d, expected 63", first_req); end
        vectors++; if (first_val != 64) begin miscompares++; $display("FAIL first_valid: got %0d, expected 64", first_val); end
        vectors++; if (nval != 225) begin miscompares++; $display("FAIL valid_per_frame: got %0d, expected 225", nval); end
        vectors++; if (nlines != 15) begin miscompares++; $display("FAIL active_lines: got %0d, expected 15", nlines); end
        vectors++; if (vrun_max != 15) begin miscompares++; $display("FAIL valid_per_line: got %0d, expected 15", vrun_max); end
        vectors++; if (hs_len != 1) begin miscompares++; $display("FAIL hsync_width: got %0d, expected 1", hs_len); end
        vectors++; if (vs_len != 20) begin miscompares++; $display("FAIL vsync_width: got %0d, expected 20", vs_len); end
        vectors++; if (fd1 != 400) begin miscompares++; $display("FAIL frame_done_first: got %0d, expected 400", fd1); end
        vectors++; if (fd2 - fd1 != 400) begin miscompares++; $display("FAIL frame_done_period: got %0d, expected 400", fd2 - fd1); end
        vectors++; if (cyc_bad != 0) begin miscompares++; $display("FAIL geometry_model: got %0d bad cycles, expected 0 (%s)", cyc_bad, bad_note); end
    endtask

    task automatic test_data_path();
        logic [7:0] q[$];
        start_run();
        for (int k = 0; k < 402; k++) begin
            if (post_img_valid) q.push_back(post_img_data);
            step();
        end
        vectors++; if (q.size() != 225) begin miscompares++; $display("FAIL data_count: got %0d, expected 225", q.size()); end
        else begin
            vectors++; if (q[0] !== 8'h00) begin miscompares++; $display("FAIL data_first: got %h, expected 00", q[0]); end
            vectors++; if (q[15] !== 8'h0F) begin miscompares++; $display("FAIL data_row1_first: got %h, expected 0f", q[15]); end
            vectors++; if (q[224] !== 8'hE0) begin miscompares++; $display("FAIL data_last: got %h, expected e0", q[224]); end
        end
        vectors++; if (cyc_bad != 0) begin miscompares++; $display("FAIL data_model: got %0d bad cycles, expected 0 (%s)", cyc_bad, bad_note); end
    endtask

    task automatic test_underflow();
        logic [7:0] q[$];
        bit uf4 = 1, uf5 = 0;
        int nval = 0;
        empty_pix = 5;
        start_run();
        for (int k = 0; k < 820; k++) begin
            if (post_img_valid && k <= 400) begin
                if (q.size() == 4) uf4 = underflow;
                if (q.size() == 5) uf5 = underflow;
                q.push_back(post_img_data);
                nval++;
            end
            step();
        end
        empty_pix = -1;
        vectors++; if (nval != 225) begin miscompares++; $display("FAIL uf_valid_count: got %0d, expected 225", nval); end
        else begin
            vectors++; if (q[4] !== 8'h04) begin miscompares++; $display("FAIL uf_pix4: got %h, expected 04", q[4]); end
            vectors++; if (q[5] !== 8'h00) begin miscompares++; $display("FAIL uf_pix5: got %h, expected 00", q[5]); end
            vectors++; if (q[6] !== 8'h05) begin miscompares++; $display("FAIL uf_pix6: got %h, expected 05", q[6]); end
        end
        vectors++; if (uf4 !== 1'b0) begin miscompares++; $display("FAIL uf_before: got %b, expected 0", uf4); end
        vectors++; if (uf5 !== 1'b1) begin miscompares++; $display("FAIL uf_set: got %b, expected 1", uf5); end
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL uf_sticky: got %b, expected 1", underflow); end
        vectors++; if (cyc_bad != 0) begin miscompares++; $display("FAIL uf_model: got %0d bad cycles, expected 0 (%s)", cyc_bad, bad_note); end
    endtask

    task automatic test_stop();
        int nfd = 0, fd_at = -1, nval = 0, idle_bad = 0;
        start_run();
        for (int k = 0; k < 500; k++) begin
            if (k == 100) en = 0;
            if (frame_done) begin nfd++; fd_at = k; end
            if (post_img_valid && k <= 400) nval++;
            if (k >= 401 && ({post_img_vsync, post_img_hsync, post_img_valid, frame_done, src_req} !== 5'b0
                             || post_img_data !== 8'h00)) idle_bad++;
            step();
        end
        vectors++; if (nfd != 1) begin miscompares++; $display("FAIL stop_frame_done_count: got %0d, expected 1", nfd); end
        vectors++; if (fd_at != 400) begin miscompares++; $display("FAIL stop_frame_done_at: got %0d, expected 400", fd_at); end
        vectors++; if (nval != 225) begin miscompares++; $display("FAIL stop_frame_valid: got %0d, expected 225", nval); end
        vectors++; if (idle_bad != 0) begin miscompares++; $display("FAIL stop_idle_outputs: got %0d active cycles, expected 0", idle_bad); end
        vectors++; if (cyc_bad != 0) begin miscompares++; $display("FAIL stop_model: got %0d bad cycles, expected 0 (%s)", cyc_bad, bad_note); end
    endtask

    task automatic test_reset_mid_frame();
        start_run();
        for (int k = 0; k < 70; k++) step();
        vectors++; if (post_img_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid: got %b, expected 1", post_img_valid); end
        rst_n = 0;
        #1;
        vectors++; if ({post_img_vsync, post_img_hsync, post_img_valid, frame_done, underflow, src_req, post_img_data} !== 14'b0) begin
            miscompares++; $display("FAIL mid_reset_outputs: got %h, expected 0",
                {post_img_vsync, post_img_hsync, post_img_valid, frame_done, underflow, src_req, post_img_data}); end
        model_reset();
        @(negedge clk);
        step(); step();
        rst_n = 1; en = 1;
        step();
        vectors++; if (post_img_vsync !== 1'b0) begin miscompares++; $display("FAIL mid_vsync_1: got %b, expected 0", post_img_vsync); end
        step();
        vectors++; if (post_img_vsync !== 1'b1) begin miscompares++; $display("FAIL mid_vsync_2: got %b, expected 1", post_img_vsync); end
        vectors++; if (cyc_bad != 0) begin miscompares++; $display("FAIL mid_model: got %0d bad cycles, expected 0 (%s)", cyc_bad, bad_note); end
    endtask

    task automatic test_random();
        start_run();
        rand_empty = 1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) en = ~en;
            step();
        end
        rand_empty = 0;
        vectors++; if (cyc_bad != 0) begin miscompares++; $display("FAIL random_model: got %0d bad cycles, expected 0 (%s)", cyc_bad, bad_note); end
    endtask

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [7:0] q[$];
        int nreq = 0;
        pattern_sel = 1;
        rand_empty = 1;
        start_run();
        for (int k = 0; k < 402; k++) begin
            if (src_req) nreq++;
            if (post_img_valid) q.push_back(post_img_data);
            step();
        end
        rand_empty = 0;
        pattern_sel = 0;
        vectors++; if (nreq != 0) begin miscompares++; $display("FAIL pat_src_req: got %0d, expected 0", nreq); end
        vectors++; if (q.size() != 225) begin miscompares++; $display("FAIL pat_count: got %0d, expected 225", q.size()); end
        else begin
            vectors++; if (q[2 * HD + 3] !== 8'h01) begin miscompares++; $display("FAIL pat_r2c3: got %h, expected 01", q[2 * HD + 3]); end
            vectors++; if (q[14 * HD + 14] !== 8'h00) begin miscompares++; $display("FAIL pat_r14c14: got %h, expected 00", q[14 * HD + 14]); end
        end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL pat_underflow: got %b, expected 0", underflow); end
        vectors++; if (cyc_bad != 0) begin miscompares++; $display("FAIL pat_model: got %0d bad cycles, expected 0 (%s)", cyc_bad, bad_note); end
    endtask
`endif

    initial begin
        model_reset();
        fifo_next = 0;
        test_reset();
        test_geometry();
        test_data_path();
        test_underflow();
        test_stop();
        test_reset_mid_frame();
        test_random();
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
